// File: rtl/ro_bus_deframer_if.sv
// Output handshake of the readout-bus deframer: tagged word, valid, ready.
interface ro_bus_deframer_if #(
  parameter int unsigned DATA_W = 7
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/ro_bus_deframer.sv
// Mirrors the gray-counter slot schedule of the shared readout bus, tags each
// sampled bus slot with its owning channel and queues it in a FWFT FIFO.
module ro_bus_deframer #(
  parameter int unsigned N_CH       = 19,
  parameter int unsigned CH_W       = 5,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                   clk_master,
  input  logic                   rstb,
  input  logic                   en,
  input  logic [N_CH-1:0]        ch_en,
  input  logic                   bus_eve,
  input  logic                   bus_pol_eve,
  ro_bus_deframer_if.master      out_if,
  output logic                   ovf,
  input  logic                   clr_ovf,
  output logic [N_CH-1:0]        slot_cnt
);

  localparam int unsigned DATA_W = CH_W + 2;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned PW     = AW + 1;

  // Slot owner: lowest set bit + 1; count 0 is the gray MSB toggling back.
  function automatic logic [CH_W-1:0] slot_owner(input logic [N_CH-1:0] c);
    slot_owner = CH_W'(N_CH);
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (c[i]) slot_owner = CH_W'(i + 1);
    end
  endfunction

  logic [N_CH-1:0]   slot_nx;
  logic [CH_W-1:0]   slot_ch;
  logic              pending;
  logic [CH_W-1:0]   pend_ch;
  logic              ch_sel;
  logic              push, pop, push_ok, drop;
  logic [DATA_W-1:0] wdata;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, wr_nx, rd_nx;
  logic              full, empty_nx;
  logic              valid_q;
  logic [DATA_W-1:0] head_q, head_nx;

  assign slot_nx = slot_cnt + N_CH'(1);
  assign slot_ch = slot_owner(slot_nx);

  // Mask lookup by channel number, no out-of-range index for any pend_ch.
  always_comb begin
    ch_sel = 1'b0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (pend_ch == CH_W'(i + 1)) ch_sel = ch_en[i];
    end
  end

  assign wdata   = {pend_ch, bus_eve, bus_pol_eve};
  assign push    = pending & ch_sel;
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = valid_q & out_if.out_ready;
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  assign wr_nx    = wr_ptr + PW'(push_ok);
  assign rd_nx    = rd_ptr + PW'(pop);
  assign empty_nx = (wr_nx == rd_nx);

  // Next head: the word being written when it lands at the new read slot.
  always_comb begin
    head_nx = '0;
    if (!empty_nx) begin
      if (push_ok && (rd_nx[AW-1:0] == wr_ptr[AW-1:0])) head_nx = wdata;
      else                                              head_nx = mem[rd_nx[AW-1:0]];
    end
  end

  always_ff @(posedge clk_master) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      slot_cnt <= '0;
      pending  <= 1'b0;
      pend_ch  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
      ovf      <= 1'b0;
    end else begin
      pending <= en;
      if (en) begin
        slot_cnt <= slot_nx;
        pend_ch  <= slot_ch;
      end
      wr_ptr  <= wr_nx;
      rd_ptr  <= rd_nx;
      valid_q <= ~empty_nx;
      head_q  <= head_nx;
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  assign out_if.out_data  = head_q;
  assign out_if.out_valid = valid_q;

endmodule
